id_ex_stage: RTL and testbench

// - ID/EX pipeline register with load-use hazard detection and EX operand-forward select generation.
// - Sits between decode and execute.
// - Its ex_rs1_data/ex_rs2_data feed the EX-stage operand forwarding muxes.
// - Its fwd_a/fwd_b drive the 2-bit Forward selects of those muxes.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fwd_sel.sv | 32 +++
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and EX operand-forward select codes.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_ID    = 2'b00;  // operand from ID/EX register
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from EX/MEM result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from MEM/WB result

endpackage : cpu_pkg

// File: rtl/fwd_sel.sv
// Per-operand forward select: picks the youngest in-flight producer of i_src.
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int unsigned AW = REG_AW
) (
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_exmem_rd,
  input  logic          i_exmem_we,
  input  logic [AW-1:0] i_memwb_rd,
  input  logic          i_memwb_we,
  output logic [1:0]    o_sel_c
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // x0 is hardwired zero, so it never has a producer worth forwarding.
  assign w_exmem_hit = i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == i_src);
  assign w_memwb_hit = i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == i_src);

  // EX/MEM holds the newer value, so it wins over MEM/WB.
  always_comb begin
    o_sel_c = FWD_ID;
    if (w_exmem_hit) begin
      o_sel_c = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      o_sel_c = FWD_MEMWB;
    end
  end

endmodule : fwd_sel

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, WB read bypass,
// EX forward-select generation and saturating bubble counters.
module id_ex_stage #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned REG_AW = cpu_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_pc;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic [REG_AW-1:0] r_ex_rd;
  logic [DATA_W-1:0] r_ex_rs1_data;
  logic [DATA_W-1:0] r_ex_rs2_data;
  logic [DATA_W-1:0] r_ex_imm;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic              r_ex_mem_read;
  logic              r_ex_reg_write;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_luh;
  logic w_rs1_byp;
  logic w_rs2_byp;

  // Load in EX whose destination is read by the instruction in decode.
  assign w_luh = r_ex_valid && r_ex_mem_read && id_valid && (r_ex_rd != '0) &&
                 ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));

  // A flush kills the dependent instruction anyway, so no stall is needed.
  assign stall = w_luh && !flush;

  // Regfile write in the same cycle is not yet visible on the read ports.
  assign w_rs1_byp = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs1);
  assign w_rs2_byp = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs2);

  // Control half of the pipeline register: bubbles clear these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_ctrl      <= '0;
      r_ex_mem_read  <= 1'b0;
      r_ex_reg_write <= 1'b0;
    end else if (flush || w_luh) begin
      r_ex_valid     <= 1'b0;
      r_ex_ctrl      <= '0;
      r_ex_mem_read  <= 1'b0;
      r_ex_reg_write <= 1'b0;
    end else begin
      r_ex_valid     <= id_valid;
      r_ex_ctrl      <= id_ctrl;
      r_ex_mem_read  <= id_mem_read;
      r_ex_reg_write <= id_reg_write;
    end
  end

  // Data half of the pipeline register: left stale across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_pc       <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
    end else if (!flush && !w_luh) begin
      r_ex_pc       <= id_pc;
      r_ex_rs1      <= id_rs1;
      r_ex_rs2      <= id_rs2;
      r_ex_rd       <= id_rd;
      r_ex_rs1_data <= w_rs1_byp ? wb_data : id_rs1_data;
      r_ex_rs2_data <= w_rs2_byp ? wb_data : id_rs2_data;
      r_ex_imm      <= id_imm;
    end
  end

  // Saturating bubble counters; flush takes priority over load-use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush) begin
      if (r_flush_cnt != CNT_MAX) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end else if (w_luh) begin
      if (r_stall_cnt != CNT_MAX) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  fwd_sel #(.AW(REG_AW)) u_fwd_a (
    .i_src      (r_ex_rs1),
    .i_exmem_rd (exmem_rd),
    .i_exmem_we (exmem_reg_write),
    .i_memwb_rd (memwb_rd),
    .i_memwb_we (memwb_reg_write),
    .o_sel_c    (fwd_a)
  );

  fwd_sel #(.AW(REG_AW)) u_fwd_b (
    .i_src      (r_ex_rs2),
    .i_exmem_rd (exmem_rd),
    .i_exmem_we (exmem_reg_write),
    .i_memwb_rd (memwb_rd),
    .i_memwb_we (memwb_reg_write),
    .o_sel_c    (fwd_b)
  );

  assign ex_valid     = r_ex_valid;
  assign ex_pc        = r_ex_pc;
  assign ex_rs1       = r_ex_rs1;
  assign ex_rs2       = r_ex_rs2;
  assign ex_rd        = r_ex_rd;
  assign ex_rs1_data  = r_ex_rs1_data;
  assign ex_rs2_data  = r_ex_rs2_data;
  assign ex_imm       = r_ex_imm;
  assign ex_ctrl      = r_ex_ctrl;
  assign ex_mem_read  = r_ex_mem_read;
  assign ex_reg_write = r_ex_reg_write;
  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a behavioural model.
module tb_id_ex_stage;

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [7:0]  id_ctrl;
  logic        id_mem_read, id_reg_write, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic [7:0]  ex_ctrl;
  logic        ex_mem_read, ex_reg_write;
  logic [1:0]  fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the EX-side state.
  logic        m_valid, m_mem_read, m_reg_write, m_known;
  logic [31:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [7:0]  m_ctrl;
  int          m_stalls, m_flushes;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .flush(flush), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == src) return 2'b01;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_luh();
    return m_valid && m_mem_read && id_valid && m_rd != 0 &&
           (m_rd == id_rs1 || m_rd == id_rs2);
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input int n);
    return (n >= int'(SAT)) ? SAT : CNT_W'(n);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_mem_read = 0; m_reg_write = 0; m_ctrl = 0; m_known = 1;
    m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_rs1_data = 0; m_rs2_data = 0; m_imm = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  task automatic set_idle();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_ctrl = 0;
    id_mem_read = 0; id_reg_write = 0; flush = 0;
    exmem_rd = 0; exmem_reg_write = 0; memwb_rd = 0; memwb_reg_write = 0;
    wb_data = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(m_valid));
    chk({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(m_ctrl));
    chk({tag, ".ex_mem_read"}, 64'(ex_mem_read), 64'(m_mem_read));
    chk({tag, ".ex_reg_write"}, 64'(ex_reg_write), 64'(m_reg_write));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(sat_cnt(m_stalls)));
    chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(sat_cnt(m_flushes)));
    if (m_known) begin
      chk({tag, ".ex_pc"}, 64'(ex_pc), 64'(m_pc));
      chk({tag, ".ex_rs1"}, 64'(ex_rs1), 64'(m_rs1));
      chk({tag, ".ex_rs2"}, 64'(ex_rs2), 64'(m_rs2));
      chk({tag, ".ex_rd"}, 64'(ex_rd), 64'(m_rd));
      chk({tag, ".ex_rs1_data"}, 64'(ex_rs1_data), 64'(m_rs1_data));
      chk({tag, ".ex_rs2_data"}, 64'(ex_rs2_data), 64'(m_rs2_data));
      chk({tag, ".ex_imm"}, 64'(ex_imm), 64'(m_imm));
    end
  endtask

  // One clock: check combinational outputs, clock, advance model, check registers.
  task automatic cycle(input string tag);
    logic luh;
    #1;
    luh = exp_luh();
    chk({tag, ".stall"}, 64'(stall), 64'(luh && !flush));
    if (m_known) begin
      chk({tag, ".fwd_a"}, 64'(fwd_a), 64'(exp_fwd(m_rs1)));
      chk({tag, ".fwd_b"}, 64'(fwd_b), 64'(exp_fwd(m_rs2)));
    end
    @(posedge clk);
    if (flush || luh) begin
      m_valid = 0; m_mem_read = 0; m_reg_write = 0; m_ctrl = 0; m_known = 0;
      if (flush) m_flushes++;
      else m_stalls++;
    end else begin
      m_valid = id_valid; m_mem_read = id_mem_read; m_reg_write = id_reg_write;
      m_ctrl = id_ctrl; m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_imm = id_imm; m_known = 1;
      m_rs1_data = (memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs1) ? wb_data : id_rs1_data;
      m_rs2_data = (memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs2) ? wb_data : id_rs2_data;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic issue_load(input logic [4:0] rd);
    set_idle();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = rd;
    id_pc = 32'h100; id_ctrl = 8'h5A;
    cycle("load");
  endtask

  initial begin
    set_idle();
    model_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset.stall", 64'(stall), 64'd0);
    chk("reset.fwd_a", 64'(fwd_a), 64'd0);
    chk("reset.fwd_b", 64'(fwd_b), 64'd0);
    @(negedge clk);
    rst = 0;

    // 1: load-use stall, one bubble, then capture.
    issue_load(5'd5);
    set_idle();
    id_valid = 1; id_rs1 = 5'd5; id_rd = 5'd6; id_pc = 32'h104; id_ctrl = 8'h11;
    #1 chk("t1.stall_hi", 64'(stall), 64'd1);
    cycle("t1.bubble");
    chk("t1.ex_valid_lo", 64'(ex_valid), 64'd0);
    chk("t1.stall_cnt", 64'(stall_cnt), 64'd1);
    chk("t1.stall_lo", 64'(stall), 64'd0);
    cycle("t1.capture");
    chk("t1.captured_pc", 64'(ex_pc), 64'h104);

    // 2: EX/MEM beats MEM/WB, then MEM/WB alone.
    set_idle();
    id_valid = 1; id_rs2 = 5'd3; id_rs1 = 5'd9;
    cycle("t2.cap");
    set_idle();
    exmem_rd = 5'd3; exmem_reg_write = 1; memwb_rd = 5'd3; memwb_reg_write = 1;
    #1 chk("t2.fwd_b_exmem", 64'(fwd_b), 64'd1);
    exmem_reg_write = 0;
    #1 chk("t2.fwd_b_memwb", 64'(fwd_b), 64'd2);
    cycle("t2.step");

    // 3: x0 never forwards nor stalls.
    set_idle();
    id_valid = 1;
    cycle("t3.cap_x0");
    exmem_rd = 0; exmem_reg_write = 1;
    #1 chk("t3.fwd_a_x0", 64'(fwd_a), 64'd0);
    issue_load(5'd0);
    set_idle();
    id_valid = 1; id_rs1 = 0;
    #1 chk("t3.stall_x0", 64'(stall), 64'd0);
    cycle("t3.nostall");

    // 4: flush together with load-use.
    issue_load(5'd8);
    set_idle();
    id_valid = 1; id_rs2 = 5'd8; flush = 1;
    #1 chk("t4.stall_masked", 64'(stall), 64'd0);
    cycle("t4.flush");
    chk("t4.flush_cnt", 64'(flush_cnt), 64'd1);
    chk("t4.stall_cnt", 64'(stall_cnt), 64'd1);

    // 5: same-cycle WB bypass into rs2 data.
    set_idle();
    id_valid = 1; id_rs2 = 5'd7; id_rs2_data = 0;
    memwb_rd = 5'd7; memwb_reg_write = 1; wb_data = 32'hDEAD_BEEF;
    cycle("t5.bypass");
    chk("t5.rs2_data", 64'(ex_rs2_data), 64'hDEAD_BEEF);

    // 6a: async reset in the middle of a stall.
    issue_load(5'd4);
    set_idle();
    id_valid = 1; id_rs1 = 5'd4;
    #1 chk("t6.stall_pre", 64'(stall), 64'd1);
    #1 rst = 1;
    #1;
    model_reset();
    check_regs("t6.async");
    chk("t6.stall_rst", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 0;

    // 6b: stall counter saturation.
    for (int i = 0; i < int'(SAT) + 2; i++) begin
      issue_load(5'd5);
      set_idle();
      id_valid = 1; id_rs1 = 5'd5;
      cycle("t6.sat");
    end
    chk("t6.stall_sat", 64'(stall_cnt), 64'(SAT));

    // Random traffic over a small register space to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      id_valid        = 1'($urandom_range(0, 3) != 0);
      id_pc           = $urandom;
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_rd           = 5'($urandom_range(0, 3));
      id_rs1_data     = $urandom;
      id_rs2_data     = $urandom;
      id_imm          = $urandom;
      id_ctrl         = 8'($urandom);
      id_mem_read     = 1'($urandom_range(0, 1));
      id_reg_write    = 1'($urandom_range(0, 1));
      flush           = 1'($urandom_range(0, 7) == 0);
      exmem_rd        = 5'($urandom_range(0, 3));
      exmem_reg_write = 1'($urandom_range(0, 1));
      memwb_rd        = 5'($urandom_range(0, 3));
      memwb_reg_write = 1'($urandom_range(0, 1));
      wb_data         = $urandom;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_id_ex_stage
